// File: rtl/sync_fifo_flex.sv
// Parametrised synchronous FIFO with selectable FWFT/registered read, runtime
// almost-full/almost-empty thresholds, occupancy count, flush and sticky error flags.
module sync_fifo_flex #(
  parameter int WIDTH     = 32,
  parameter int DEPTH_LEN = 4,
  parameter bit FWFT      = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  input  logic [WIDTH-1:0]     i_data,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [DEPTH_LEN:0]   i_afull_thr,
  input  logic [DEPTH_LEN:0]   i_aempty_thr,
  output logic [WIDTH-1:0]     o_data,
  output logic                 o_valid,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_afull,
  output logic                 o_aempty,
  output logic [DEPTH_LEN:0]   o_count,
  output logic                 o_overflow,
  output logic                 o_underflow
);

  localparam int DEPTH = 1 << DEPTH_LEN;
  localparam logic [DEPTH_LEN:0] DEPTH_CNT = (DEPTH_LEN + 1)'(DEPTH);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_LEN:0] wr_ptr;
  logic [DEPTH_LEN:0] rd_ptr;
  logic               rd_acc;
  logic               wr_acc;

  // Status is derived from registered pointers only; the extra pointer bit
  // lets count reach DEPTH without aliasing to empty.
  assign o_count  = wr_ptr - rd_ptr;
  assign o_empty  = (o_count == '0);
  assign o_full   = (o_count == DEPTH_CNT);
  assign o_afull  = (o_count >= i_afull_thr);
  assign o_aempty = (o_count <= i_aempty_thr);

  // A full FIFO still accepts a write when a read retires a word in the same cycle.
  assign rd_acc = rd_en & ~o_empty & ~i_flush & ~i_rst;
  assign wr_acc = wr_en & (~o_full | rd_acc) & ~i_flush & ~i_rst;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (wr_en && o_full && !rd_acc) o_overflow  <= 1'b1;
      if (rd_en && o_empty)           o_underflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; pointers alone define which
  // entries are meaningful, and leaving it unreset lets it map to RAM/regfile.
  always_ff @(posedge i_clk) begin
    if (wr_acc) mem[wr_ptr[DEPTH_LEN-1:0]] <= i_data;
  end

  generate
    if (FWFT) begin : g_fwft
      assign o_data  = mem[rd_ptr[DEPTH_LEN-1:0]];
      assign o_valid = ~o_empty;
    end else begin : g_reg
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          o_data  <= '0;
          o_valid <= 1'b0;
        end else if (rd_acc) begin
          o_data  <= mem[rd_ptr[DEPTH_LEN-1:0]];
          o_valid <= 1'b1;
        end else begin
          o_valid <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench: an FWFT and a registered-read FIFO share one stimulus stream,
// each checked against hand-computed expectations.
module tb_sync_fifo_flex;

  localparam int W  = 8;
  localparam int DL = 2;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_flush;
  logic [W-1:0]  i_data;
  logic          wr_en;
  logic          rd_en;
  logic [DL:0]   i_afull_thr;
  logic [DL:0]   i_aempty_thr;

  logic [W-1:0]  f_data, r_data;
  logic          f_valid, r_valid;
  logic          f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
  logic          r_full, r_empty, r_afull, r_aempty, r_ovf, r_unf;
  logic [DL:0]   f_count, r_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clk = ~i_clk;

  sync_fifo_flex #(.WIDTH(W), .DEPTH_LEN(DL), .FWFT(1'b1)) u_fwft (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_data(i_data),
    .wr_en(wr_en), .rd_en(rd_en), .i_afull_thr(i_afull_thr), .i_aempty_thr(i_aempty_thr),
    .o_data(f_data), .o_valid(f_valid), .o_full(f_full), .o_empty(f_empty),
    .o_afull(f_afull), .o_aempty(f_aempty), .o_count(f_count),
    .o_overflow(f_ovf), .o_underflow(f_unf)
  );

  sync_fifo_flex #(.WIDTH(W), .DEPTH_LEN(DL), .FWFT(1'b0)) u_reg (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_data(i_data),
    .wr_en(wr_en), .rd_en(rd_en), .i_afull_thr(i_afull_thr), .i_aempty_thr(i_aempty_thr),
    .o_data(r_data), .o_valid(r_valid), .o_full(r_full), .o_empty(r_empty),
    .o_afull(r_afull), .o_aempty(r_aempty), .o_count(r_count),
    .o_overflow(r_ovf), .o_underflow(r_unf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [W-1:0] d);
    i_data = d; wr_en = 1'b1; rd_en = 1'b0;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic rd();
    wr_en = 1'b0; rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"},  32'(f_count), 32'd0);
    check({tag, "_empty"},  32'(f_empty), 32'd1);
    check({tag, "_full"},   32'(f_full),  32'd0);
    check({tag, "_aempty"}, 32'(f_aempty), 32'd1);
    check({tag, "_afull"},  32'(f_afull), 32'd0);
    check({tag, "_fvalid"}, 32'(f_valid), 32'd0);
    check({tag, "_rvalid"}, 32'(r_valid), 32'd0);
    check({tag, "_ovf"},    32'(f_ovf),   32'd0);
    check({tag, "_unf"},    32'(f_unf),   32'd0);
    check({tag, "_rdata"},  32'(r_data),  32'd0);
  endtask

  logic [W-1:0] exp_d;
  logic [DL:0]  exp_c;

  initial begin
    i_rst = 1'b1; i_flush = 1'b0; i_data = '0; wr_en = 1'b0; rd_en = 1'b0;
    i_afull_thr = 3'd3; i_aempty_thr = 3'd1;

    // Reset state, including write request ignored while in reset
    wr_en = 1'b1; i_data = 8'hEE;
    cyc(); cyc();
    wr_en = 1'b0;
    check_reset_state("rst0");
    i_afull_thr = 3'd0;
    #1 check("thr0_afull", 32'(f_afull), 32'd1);
    i_afull_thr = 3'd3;
    i_rst = 1'b0;
    cyc();

    // Fill to full, tracking threshold flags
    wr(8'h11);
    check("w1_fdata", 32'(f_data), 32'h11);
    check("w1_aempty", 32'(f_aempty), 32'd1);
    wr(8'h22);
    check("w2_aempty", 32'(f_aempty), 32'd0);
    check("w2_afull", 32'(f_afull), 32'd0);
    wr(8'h33);
    check("w3_afull", 32'(f_afull), 32'd1);
    wr(8'h44);
    check("w4_full", 32'(f_full), 32'd1);
    check("w4_count", 32'(f_count), 32'd4);
    check("w4_rempty", 32'(r_empty), 32'd0);

    // Full FIFO: write and read in the same cycle
    check("wr_rd_head", 32'(f_data), 32'h11);
    i_data = 8'h99; wr_en = 1'b1; rd_en = 1'b1;
    cyc();
    wr_en = 1'b0; rd_en = 1'b0;
    check("wr_rd_count", 32'(f_count), 32'd4);
    check("wr_rd_ovf", 32'(f_ovf), 32'd0);
    check("wr_rd_rvalid", 32'(r_valid), 32'd1);
    check("wr_rd_rdata", 32'(r_data), 32'h11);

    // Drain: 22,33,44,99
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: exp_d = 8'h22;
        1: exp_d = 8'h33;
        2: exp_d = 8'h44;
        default: exp_d = 8'h99;
      endcase
      check($sformatf("drain1_f%0d", i), 32'(f_data), 32'(exp_d));
      rd();
      check($sformatf("drain1_r%0d", i), 32'(r_data), 32'(exp_d));
    end
    check("drain1_empty", 32'(f_empty), 32'd1);
    cyc();
    check("drain1_rvalid_off", 32'(r_valid), 32'd0);

    // Refill, overflow on the fifth write, drain in order
    wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
    wr(8'h55);
    check("ovf_flag", 32'(f_ovf), 32'd1);
    check("ovf_count", 32'(f_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      exp_d = 8'(8'h11 * (i + 1));
      check($sformatf("drain2_f%0d", i), 32'(f_data), 32'(exp_d));
      rd();
    end
    check("drain2_empty", 32'(f_empty), 32'd1);
    check("ovf_sticky", 32'(f_ovf), 32'd1);

    // Read on empty: underflow, no valid pulse
    rd();
    check("unf_flag", 32'(r_unf), 32'd1);
    check("unf_rvalid", 32'(r_valid), 32'd0);

    // Flush clears error flags
    i_flush = 1'b1; cyc(); i_flush = 1'b0;
    check("flush_ovf", 32'(f_ovf), 32'd0);
    check("flush_unf", 32'(r_unf), 32'd0);

    // Registered read: one-cycle valid pulse, data holds afterwards
    wr(8'hA5);
    rd();
    check("reg_valid", 32'(r_valid), 32'd1);
    check("reg_data", 32'(r_data), 32'hA5);
    cyc();
    check("reg_valid_off", 32'(r_valid), 32'd0);
    check("reg_data_hold", 32'(r_data), 32'hA5);

    // Three fill/drain rounds: pointers wrap, thresholds tracked at each count
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        wr(8'(8'h40 + 16 * k + i));
        exp_c = 3'(i + 1);
        check($sformatf("wrap%0d_cnt%0d", k, i), 32'(f_count), 32'(exp_c));
        check($sformatf("wrap%0d_ae%0d", k, i), 32'(f_aempty), 32'(exp_c <= 3'd1));
        check($sformatf("wrap%0d_af%0d", k, i), 32'(f_afull), 32'(exp_c >= 3'd3));
      end
      for (int i = 0; i < 4; i++) begin
        exp_d = 8'(8'h40 + 16 * k + i);
        check($sformatf("wrap%0d_f%0d", k, i), 32'(f_data), 32'(exp_d));
        rd();
        check($sformatf("wrap%0d_r%0d", k, i), 32'(r_data), 32'(exp_d));
      end
      check($sformatf("wrap%0d_empty", k), 32'(f_empty), 32'd1);
      check($sformatf("wrap%0d_ae0", k), 32'(f_aempty), 32'd1);
    end

    // Write with read on empty: write only, read rejected
    i_data = 8'h3C; wr_en = 1'b1; rd_en = 1'b1;
    cyc();
    wr_en = 1'b0; rd_en = 1'b0;
    check("wre_count", 32'(f_count), 32'd1);
    check("wre_unf", 32'(f_unf), 32'd1);
    check("wre_rvalid", 32'(r_valid), 32'd0);
    check("wre_fdata", 32'(f_data), 32'h3C);

    // Half-full flush with a concurrent write that must be dropped
    wr(8'h01);
    check("half_count", 32'(f_count), 32'd2);
    i_flush = 1'b1; i_data = 8'h03; wr_en = 1'b1;
    cyc();
    i_flush = 1'b0; wr_en = 1'b0;
    check("fl_count", 32'(f_count), 32'd0);
    check("fl_empty", 32'(f_empty), 32'd1);
    check("fl_ovf", 32'(f_ovf), 32'd0);
    check("fl_unf", 32'(f_unf), 32'd0);
    cyc();
    check("fl_count_idle", 32'(f_count), 32'd0);

    // Reset mid-stream: 3 words with overflow set
    wr(8'h61); wr(8'h62); wr(8'h63); wr(8'h64);
    wr(8'h65);
    rd();
    check("mid_count", 32'(f_count), 32'd3);
    check("mid_ovf", 32'(f_ovf), 32'd1);
    check("mid_rdata", 32'(r_data), 32'h61);
    i_rst = 1'b1; i_flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; i_data = 8'hDD;
    cyc();
    i_rst = 1'b0; i_flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    check_reset_state("rst1");
    wr(8'h7E);
    check("post_fdata", 32'(f_data), 32'h7E);
    check("post_count", 32'(f_count), 32'd1);
    rd();
    check("post_rvalid", 32'(r_valid), 32'd1);
    check("post_rdata", 32'(r_data), 32'h7E);
    check("post_empty", 32'(r_empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
